gb_bus_capture: RTL



---
 rtl/gb_bus_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gb_bus_capture.sv
// Game Boy cartridge bus front-end: synchronises and debounces GB_WR, emits one WR_STB per write.
// Optional GBC_GLITCH_CNT_EN adds a saturating GLITCH_CNT of rejected/bounced WR edges.
module gb_bus_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int CNT_W       = 3
) (
  input  logic       CLK,
  input  logic       GB_RST,
  input  logic [3:0] GB_A,
  input  logic [7:0] GB_D,
  input  logic       GB_CS,
  input  logic       GB_WR,
  input  logic       GB_RD,
  input  logic       ERR_CLR,
  output logic       WR_STB,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_CS,
  output logic       RD_ACT,
  output logic       BUS_ERR
`ifdef GBC_GLITCH_CNT_EN
  ,
  output logic [7:0] GLITCH_CNT
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_QUAL, S_ACTIVE, S_RELEASE, S_ABORT} state_t;
  localparam logic [CNT_W-1:0] FL = CNT_W'(FILT_LEN);

  logic [SYNC_STAGES-1:0]      r_wr_sync, r_rd_sync, r_cs_sync;
  logic [SYNC_STAGES-1:0][3:0] r_a_sync;
  logic [SYNC_STAGES-1:0][7:0] r_d_sync;
  logic                        w_wr_s, w_rd_s, w_cs_s;
  logic [3:0]                  w_a_s;
  logic [7:0]                  w_d_s;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       r_hold_a;
  logic [7:0]       r_hold_d;
  logic             r_hold_cs;
  logic             w_busy, w_viol, w_cap, w_stb;

  // Address/data ride the same flop depth as the strobes so samples stay aligned with wr_s.
  always_ff @(posedge CLK) begin
    if (!GB_RST) begin
      r_wr_sync <= '1;
      r_rd_sync <= '1;
      r_cs_sync <= '1;
      r_a_sync  <= '0;
      r_d_sync  <= '0;
    end else begin
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], GB_WR};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], GB_RD};
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], GB_CS};
      r_a_sync  <= {r_a_sync[SYNC_STAGES-2:0], GB_A};
      r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], GB_D};
    end
  end

  assign w_wr_s    = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_a_s     = r_a_sync[SYNC_STAGES-1];
  assign w_d_s     = r_d_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + 1'b1;

  assign w_busy = (r_state == S_QUAL) || (r_state == S_ACTIVE) || (r_state == S_RELEASE);
  assign w_viol = !w_rd_s && (w_busy || ((r_state == S_IDLE) && !w_wr_s));
  // Sampling every low edge leaves the holding regs with the trailing-edge values.
  assign w_cap  = !w_wr_s && !w_viol && (r_state != S_ABORT);
  assign w_stb  = !w_viol && w_wr_s &&
                  (((r_state == S_ACTIVE) && (FILT_LEN == 1)) ||
                   ((r_state == S_RELEASE) && (w_cnt_inc == FL)));

  always_ff @(posedge CLK) begin
    if (!GB_RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hold_a  <= '0;
      r_hold_d  <= '0;
      r_hold_cs <= 1'b1;
      WR_STB    <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      WR_CS     <= 1'b1;
      RD_ACT    <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      WR_STB <= w_stb;
      RD_ACT <= ~w_rd_s;
      if (w_cap) begin
        r_hold_a  <= w_a_s;
        r_hold_d  <= w_d_s;
        r_hold_cs <= w_cs_s;
      end
      if (w_stb) begin
        WR_ADDR <= r_hold_a;
        WR_DATA <= r_hold_d;
        WR_CS   <= r_hold_cs;
      end
      if (w_viol)       BUS_ERR <= 1'b1;
      else if (ERR_CLR) BUS_ERR <= 1'b0;

      if (w_viol) begin
        r_state <= S_ABORT;
      end else begin
        case (r_state)
          S_IDLE: if (!w_wr_s) begin
            r_state <= (FILT_LEN == 1) ? S_ACTIVE : S_QUAL;
            r_cnt   <= CNT_W'(1);
          end
          S_QUAL: begin
            if (w_wr_s) r_state <= S_IDLE;
            else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == FL) r_state <= S_ACTIVE;
            end
          end
          S_ACTIVE: if (w_wr_s) begin
            r_state <= (FILT_LEN == 1) ? S_IDLE : S_RELEASE;
            r_cnt   <= CNT_W'(1);
          end
          S_RELEASE: begin
            if (!w_wr_s) r_state <= S_ACTIVE;
            else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == FL) r_state <= S_IDLE;
            end
          end
          S_ABORT: if (w_wr_s && w_rd_s) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef GBC_GLITCH_CNT_EN
  logic w_reject, w_bounce;
  assign w_reject = (r_state == S_QUAL) && w_wr_s && w_rd_s;
  assign w_bounce = (r_state == S_RELEASE) && !w_wr_s && w_rd_s;

  always_ff @(posedge CLK) begin
    if (!GB_RST)      GLITCH_CNT <= '0;
    else if (ERR_CLR) GLITCH_CNT <= '0;
    else if ((w_reject || w_bounce) && (GLITCH_CNT != 8'hFF))
      GLITCH_CNT <= GLITCH_CNT + 8'd1;
  end
`endif

endmodule
